// File: rtl/arrow_sequence_player.sv
// Arrow sequence player: stores up to MAX_LEN direction codes and replays them
// as timed arrow pulses (ON_TICKS shown, OFF_TICKS blank), with a done pulse at the end.
//
// state | meaning
// IDLE  | accept clear/start/load; buffer editable
// SHOW  | current entry decoded onto the arrow outputs for ON_TICKS cycles
// GAP   | all arrows blank for OFF_TICKS cycles
// DONE  | single-cycle done pulse, then back to IDLE
module arrow_sequence_player #(
    parameter int MAX_LEN   = 16,
    parameter int ON_TICKS  = 25000000,
    parameter int OFF_TICKS = 12500000
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic                         load_valid,
    input  logic [2:0]                   load_dir,
    input  logic                         clear,
    input  logic                         start,
    output logic                         arrow_left,
    output logic                         arrow_right,
    output logic                         arrow_up,
    output logic                         arrow_down,
    output logic                         busy,
    output logic                         done,
    output logic                         full,
    output logic [$clog2(MAX_LEN):0]     count,
    output logic [$clog2(MAX_LEN)-1:0]   play_index
);

    localparam int IW    = $clog2(MAX_LEN);
    localparam int CW    = IW + 1;
    localparam int MAX_T = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int TW    = (MAX_T > 1) ? $clog2(MAX_T) : 1;

    localparam logic [TW-1:0] ON_LAST  = TW'(ON_TICKS - 1);
    localparam logic [TW-1:0] OFF_LAST = TW'(OFF_TICKS - 1);
    localparam logic [CW-1:0] LEN_MAX  = CW'(MAX_LEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [TW-1:0]   timer, timer_nxt;
    logic [IW-1:0]   index_nxt;
    logic [CW-1:0]   count_nxt;
    logic [CW-1:0]   last_index;
    logic [3:0]      arrows, arrows_nxt;
    logic            wr_en;
    logic [2:0]      mem [MAX_LEN];

    // {left, down, up, right}; codes 100..111 show nothing
    function automatic logic [3:0] decode(input logic [2:0] code);
        logic [3:0] a;
        a = 4'b0000;
        case (code)
            3'b000:  a = 4'b1000;
            3'b001:  a = 4'b0100;
            3'b010:  a = 4'b0010;
            3'b011:  a = 4'b0001;
            default: a = 4'b0000;
        endcase
        return a;
    endfunction

    assign last_index = count - CW'(1);

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        index_nxt = play_index;
        count_nxt = count;
        wr_en     = 1'b0;

        case (state)
            IDLE: begin
                timer_nxt = '0;
                index_nxt = '0;
                if (clear) begin
                    count_nxt = '0;
                end else if (start) begin
                    state_nxt = (count != '0) ? SHOW : DONE;
                end else if (load_valid && !full) begin
                    wr_en     = 1'b1;
                    count_nxt = count + CW'(1);
                end
            end
            SHOW: begin
                if (timer == ON_LAST) begin
                    state_nxt = GAP;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            GAP: begin
                if (timer == OFF_LAST) begin
                    timer_nxt = '0;
                    if (CW'(play_index) == last_index) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = SHOW;
                        index_nxt = play_index + IW'(1);
                    end
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
                timer_nxt = '0;
                index_nxt = '0;
            end
            default: begin
                state_nxt = IDLE;
                timer_nxt = '0;
                index_nxt = '0;
            end
        endcase

        // Arrows are computed from the next state so the output flops line up
        // exactly with the SHOW state; the buffer cannot change while playing.
        arrows_nxt = (state_nxt == SHOW) ? decode(mem[index_nxt]) : 4'b0000;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            timer      <= '0;
            play_index <= '0;
            count      <= '0;
            arrows     <= 4'b0000;
        end else begin
            state      <= state_nxt;
            timer      <= timer_nxt;
            play_index <= index_nxt;
            count      <= count_nxt;
            arrows     <= arrows_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[count[IW-1:0]] <= load_dir;
        end
    end

    assign arrow_left  = arrows[3];
    assign arrow_down  = arrows[2];
    assign arrow_up    = arrows[1];
    assign arrow_right = arrows[0];
    assign busy        = (state == SHOW) || (state == GAP);
    assign done        = (state == DONE);
    assign full        = (count == LEN_MAX);

endmodule

// File: tb/tb_arrow_sequence_player.sv
// Directed bench for arrow_sequence_player with ON_TICKS=4, OFF_TICKS=2, MAX_LEN=4.
module tb_arrow_sequence_player;

    localparam int MAX_LEN   = 4;
    localparam int ON_TICKS  = 4;
    localparam int OFF_TICKS = 2;

    localparam logic [3:0] NONE  = 4'b0000;
    localparam logic [3:0] LEFT  = 4'b1000;
    localparam logic [3:0] DOWN  = 4'b0100;
    localparam logic [3:0] UP    = 4'b0010;
    localparam logic [3:0] RIGHT = 4'b0001;

    logic       clock;
    logic       resetn;
    logic       load_valid;
    logic [2:0] load_dir;
    logic       clear;
    logic       start;
    logic       arrow_left, arrow_right, arrow_up, arrow_down;
    logic       busy, done, full;
    logic [2:0] count;
    logic [1:0] play_index;

    int n_checks = 0;
    int n_fails  = 0;

    arrow_sequence_player #(
        .MAX_LEN  (MAX_LEN),
        .ON_TICKS (ON_TICKS),
        .OFF_TICKS(OFF_TICKS)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .load_valid (load_valid),
        .load_dir   (load_dir),
        .clear      (clear),
        .start      (start),
        .arrow_left (arrow_left),
        .arrow_right(arrow_right),
        .arrow_up   (arrow_up),
        .arrow_down (arrow_down),
        .busy       (busy),
        .done       (done),
        .full       (full),
        .count      (count),
        .play_index (play_index)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [3:0] arrows();
        return {arrow_left, arrow_down, arrow_up, arrow_right};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input logic [2:0] dir);
        load_valid = 1'b1;
        load_dir   = dir;
        step();
        load_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    // Check n consecutive cycles; optionally hammer load/clear/start meanwhile.
    task automatic expect_phase(input string tag, input int n, input logic [3:0] arr,
                                input logic exp_busy, input logic exp_done,
                                input logic [1:0] idx, input logic disturb);
        for (int i = 0; i < n; i++) begin
            check({tag, " arrows"}, 32'(arrows()), 32'(arr));
            check({tag, " busy"}, 32'(busy), 32'(exp_busy));
            check({tag, " done"}, 32'(done), 32'(exp_done));
            if (exp_busy) check({tag, " index"}, 32'(play_index), 32'(idx));
            load_valid = disturb;
            clear      = disturb;
            start      = disturb;
            load_dir   = 3'b011;
            step();
        end
        load_valid = 1'b0;
        clear      = 1'b0;
        start      = 1'b0;
    endtask

    task automatic expect_idle(input string tag, input logic [2:0] exp_count);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " done"}, 32'(done), 32'd0);
        check({tag, " arrows"}, 32'(arrows()), 32'(NONE));
        check({tag, " index"}, 32'(play_index), 32'd0);
        check({tag, " count"}, 32'(count), 32'(exp_count));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn     = 1'b0;
        load_valid = 1'b0;
        load_dir   = 3'b000;
        clear      = 1'b0;
        start      = 1'b0;
        step();
        step();
        expect_idle("reset", 3'd0);
        check("reset full", 32'(full), 32'd0);
        resetn = 1'b1;

        // right, left, up
        load(3'b011);
        load(3'b000);
        load(3'b010);
        check("seq1 count", 32'(count), 32'd3);
        check("seq1 full", 32'(full), 32'd0);
        pulse_start();
        expect_phase("seq1 show0", ON_TICKS, RIGHT, 1'b1, 1'b0, 2'd0, 1'b0);
        expect_phase("seq1 gap0", OFF_TICKS, NONE, 1'b1, 1'b0, 2'd0, 1'b0);
        expect_phase("seq1 show1", ON_TICKS, LEFT, 1'b1, 1'b0, 2'd1, 1'b0);
        expect_phase("seq1 gap1", OFF_TICKS, NONE, 1'b1, 1'b0, 2'd1, 1'b0);
        expect_phase("seq1 show2", ON_TICKS, UP, 1'b1, 1'b0, 2'd2, 1'b0);
        expect_phase("seq1 gap2", OFF_TICKS, NONE, 1'b1, 1'b0, 2'd2, 1'b0);
        expect_phase("seq1 done", 1, NONE, 1'b0, 1'b1, 2'd0, 1'b0);
        expect_idle("seq1 after", 3'd3);

        // empty buffer: immediate done, nothing shown
        pulse_clear();
        expect_idle("clear", 3'd0);
        pulse_start();
        expect_phase("empty done", 1, NONE, 1'b0, 1'b1, 2'd0, 1'b0);
        expect_idle("empty after", 3'd0);

        // overfill: fifth load dropped
        load(3'b000);
        load(3'b001);
        load(3'b010);
        check("fill3 full", 32'(full), 32'd0);
        load(3'b011);
        check("fill4 count", 32'(count), 32'd4);
        check("fill4 full", 32'(full), 32'd1);
        load(3'b010);
        check("fill5 count", 32'(count), 32'd4);
        check("fill5 full", 32'(full), 32'd1);
        pulse_start();
        expect_phase("full show0", ON_TICKS, LEFT, 1'b1, 1'b0, 2'd0, 1'b0);
        expect_phase("full gap0", OFF_TICKS, NONE, 1'b1, 1'b0, 2'd0, 1'b0);
        expect_phase("full show1", ON_TICKS, DOWN, 1'b1, 1'b0, 2'd1, 1'b0);
        expect_phase("full gap1", OFF_TICKS, NONE, 1'b1, 1'b0, 2'd1, 1'b0);
        expect_phase("full show2", ON_TICKS, UP, 1'b1, 1'b0, 2'd2, 1'b0);
        expect_phase("full gap2", OFF_TICKS, NONE, 1'b1, 1'b0, 2'd2, 1'b0);
        expect_phase("full show3", ON_TICKS, RIGHT, 1'b1, 1'b0, 2'd3, 1'b0);
        expect_phase("full gap3", OFF_TICKS, NONE, 1'b1, 1'b0, 2'd3, 1'b0);
        expect_phase("full done", 1, NONE, 1'b0, 1'b1, 2'd0, 1'b0);
        expect_idle("full after", 3'd4);

        // NOTHING code, with load/clear/start hammered during playback
        pulse_clear();
        load(3'b111);
        load(3'b001);
        pulse_start();
        expect_phase("dist show0", ON_TICKS, NONE, 1'b1, 1'b0, 2'd0, 1'b1);
        expect_phase("dist gap0", OFF_TICKS, NONE, 1'b1, 1'b0, 2'd0, 1'b1);
        expect_phase("dist show1", ON_TICKS, DOWN, 1'b1, 1'b0, 2'd1, 1'b1);
        expect_phase("dist gap1", OFF_TICKS, NONE, 1'b1, 1'b0, 2'd1, 1'b0);
        expect_phase("dist done", 1, NONE, 1'b0, 1'b1, 2'd0, 1'b0);
        expect_idle("dist after", 3'd2);
        pulse_start();
        expect_phase("replay show0", ON_TICKS, NONE, 1'b1, 1'b0, 2'd0, 1'b0);
        expect_phase("replay gap0", OFF_TICKS, NONE, 1'b1, 1'b0, 2'd0, 1'b0);
        expect_phase("replay show1", ON_TICKS, DOWN, 1'b1, 1'b0, 2'd1, 1'b0);
        expect_phase("replay gap1", OFF_TICKS, NONE, 1'b1, 1'b0, 2'd1, 1'b0);
        expect_phase("replay done", 1, NONE, 1'b0, 1'b1, 2'd0, 1'b0);

        // reset during third SHOW cycle
        pulse_clear();
        load(3'b011);
        pulse_start();
        expect_phase("abort show", 2, RIGHT, 1'b1, 1'b0, 2'd0, 1'b0);
        check("abort pre arrows", 32'(arrows()), 32'(RIGHT));
        #2;
        resetn = 1'b0;
        #1;
        expect_idle("abort async", 3'd0);
        check("abort async full", 32'(full), 32'd0);
        step();
        expect_idle("abort held", 3'd0);
        resetn = 1'b1;
        step();
        expect_idle("abort released", 3'd0);
        load(3'b010);
        check("post reset count", 32'(count), 32'd1);
        pulse_start();
        expect_phase("post show0", ON_TICKS, UP, 1'b1, 1'b0, 2'd0, 1'b0);
        expect_phase("post gap0", OFF_TICKS, NONE, 1'b1, 1'b0, 2'd0, 1'b0);
        expect_phase("post done", 1, NONE, 1'b0, 1'b1, 2'd0, 1'b0);
        expect_idle("post after", 3'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
